// File: rtl/shift_add_multiplier_if.sv
// Operand-entry and result bus for the shift-and-add multiplier.
interface shift_add_multiplier_if;
   logic        start;
   logic        toggle;
   logic        push;
   logic [15:0] user_input;
   logic [31:0] product;
   logic        valid;
   logic        busy;

   modport master (
      output start, toggle, push, user_input,
      input  product, valid, busy
   );

   modport slave (
      input  start, toggle, push, user_input,
      output product, valid, busy
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier with an 8-digit
// multiplexed hex display of the product.
module shift_add_multiplier #(
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   shift_add_multiplier_if.slave  bus,
   output logic [6:0]             seg,
   output logic [7:0]             an
);

   localparam int unsigned OP_W   = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DIG_W  = 3;

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] MULTIPLY = 1'b1;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(15);

   logic [0:0]        state_q, state_d;
   logic [OP_W-1:0]   mcand_q, mplier_q;
   logic [OP_W-1:0]   m_q, m_d;
   // Working register {acc, q}; the carry exists only inside sum_c because
   // the shift always moves it into acc[15] in the same cycle.
   logic [PROD_W-1:0] work_q, work_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PROD_W-1:0] product_q, product_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic [OP_W:0]     sum_c;

   logic [REFRESH_BITS-1:0] refresh_q;
   logic [DIG_W-1:0]        digit_c;
   logic [3:0]              nibble_c;
   logic [6:0]              glyph_c;
   logic [6:0]              seg_q;
   logic [7:0]              an_q;

   assign bus.product = product_q;
   assign bus.valid   = valid_q;
   assign bus.busy    = busy_q;
   assign seg         = seg_q;
   assign an          = an_q;

   // Operand registers; pushes are honoured in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (bus.push) begin
         if (bus.toggle) mplier_q <= bus.user_input;
         else            mcand_q  <= bus.user_input;
      end
   end

   // Multiplier state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         work_q    <= '0;
         count_q   <= '0;
         product_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         work_q    <= work_d;
         count_q   <= count_d;
         product_q <= product_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic: start/fast-path in IDLE, one add-and-shift per cycle in MULTIPLY.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      work_d    = work_q;
      count_d   = count_q;
      product_d = product_q;
      valid_d   = 1'b0;
      sum_c     = {1'b0, work_q[PROD_W-1:OP_W]} + (work_q[0] ? {1'b0, m_q} : (OP_W+1)'(0));

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if ((mcand_q == '0) || (mplier_q == '0)) begin
                  product_d = '0;
                  valid_d   = 1'b1;
               end else begin
                  m_d     = mcand_q;
                  work_d  = {OP_W'(0), mplier_q};
                  count_d = '0;
                  state_d = MULTIPLY;
               end
            end
         end
         MULTIPLY: begin
            work_d  = {sum_c, work_q[OP_W-1:1]};
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ITER) begin
               product_d = work_d;
               valid_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == MULTIPLY);
   end

   // Digit select and hex glyph lookup for the current refresh slot.
   always_comb begin
      digit_c  = refresh_q[REFRESH_BITS-1 -: DIG_W];
      nibble_c = product_q[{digit_c, 2'b00} +: 4];
      case (nibble_c)
         4'h0:    glyph_c = 7'b1000000;
         4'h1:    glyph_c = 7'b1111001;
         4'h2:    glyph_c = 7'b0100100;
         4'h3:    glyph_c = 7'b0110000;
         4'h4:    glyph_c = 7'b0011001;
         4'h5:    glyph_c = 7'b0010010;
         4'h6:    glyph_c = 7'b0000010;
         4'h7:    glyph_c = 7'b1111000;
         4'h8:    glyph_c = 7'b0000000;
         4'h9:    glyph_c = 7'b0010000;
         4'hA:    glyph_c = 7'b0001000;
         4'hB:    glyph_c = 7'b0000011;
         4'hC:    glyph_c = 7'b1000110;
         4'hD:    glyph_c = 7'b0100001;
         4'hE:    glyph_c = 7'b0000110;
         default: glyph_c = 7'b0001110;
      endcase
   end

   // Free-running refresh counter and registered display drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_q <= '0;
         an_q      <= 8'b1111_1110;
         seg_q     <= 7'b1000000;
      end else begin
         refresh_q <= refresh_q + REFRESH_BITS'(1);
         an_q      <= ~(8'(1) << digit_c);
         seg_q     <= glyph_c;
      end
   end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential 16×16 unsigned shift-and-add multiplier, the companion to the team's restoring divider. It shares the divider's operand-entry front end: push/toggle loading from a 16-bit user input, start-triggered operation, and a one-cycle valid pulse. It produces a 32-bit product in 16 iteration cycles and drives an 8-digit multiplexed hex display of the product for the board top level.

## Interface
- REFRESH_BITS, default 17: width of the free-running display refresh counter. The top 3 bits select the digit.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled request to begin a multiply. Sampled only in IDLE.
- toggle  in  1  operand select for push: 0 = multiplicand, 1 = multiplier.
- push  in  1  writes user_input into the operand register selected by toggle.
- user_input  in  16  operand value.
- product  out  32  result register, unsigned.
- valid  out  1  one-cycle pulse when product is updated.
- busy  out  1  high while state is MULTIPLY.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, one-hot-zero.

## Operation
- Operand registers mcand and mplier (16 bits each) reset to 0.
  - On each rising edge with push=1, the register selected by toggle is written.
  - Push is honoured in any state. The in-flight operation uses copies latched at start, so mid-operation pushes never affect it.
- Datapath: a 33-bit working register {carry, acc[15:0], q[15:0]} plus a latched 16-bit multiplicand m.
- States: IDLE, MULTIPLY. There is no other state.
- IDLE with start=1:
  - If mcand==0 or mplier==0 (zero fast path): product<=0, valid<=1, stay in IDLE.
  - Otherwise: m<=mcand, work<={1'b0,16'd0,mplier}, count<=0, go to MULTIPLY.
- IDLE with start=0: hold product; no change.
- MULTIPLY, each cycle:
  - If q[0]=1, {carry,acc} = acc + m as a 17-bit sum; otherwise {carry,acc} is unchanged.
  - Logical right shift of the 33-bit register by 1, with carry shifting into acc[15].
  - count increments.
  - When count==15, product <= the final {acc,q}, valid<=1, and the state returns to IDLE.
- start is ignored while in MULTIPLY. A held start re-triggers one cycle after returning to IDLE.
- product holds its value until the next completed or fast-path operation. It is not cleared in IDLE.
- Arithmetic wraps on neither operand. The product is the exact 32-bit result, with maximum 0xFFFE0001.
- Display:
  - The refresh counter is free-running, REFRESH_BITS wide, and wraps.
  - d = counter[REFRESH_BITS-1 -: 3] selects the digit.
  - an[d]=0 and all other an bits are 1.
  - seg shows the hex glyph of product[4d+3:4d], with glyphs 0–F in standard 7-segment form.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE, product=0, valid=0, busy=0, mcand=mplier=0.
  - Refresh counter = 0, so an=8'b11111110 and seg=7'b1000000 ("0").
- Reset mid-operation aborts immediately to the values above. No valid is produced.
- Normal latency: start is accepted at edge k. busy is high after edge k through edge k+16. The valid pulse and the new product are registered at edge k+16.
  - The next start can be accepted at edge k+17.
- Fast-path latency: valid and product=0 are registered at edge k, the same edge that accepts start. busy stays 0.
- valid is high for exactly one cycle per operation, including the fast path.
- Simultaneous push and start at the same edge: the operation uses the pre-edge operand values, and the push updates the register.
- The display digit advances every 2^(REFRESH_BITS-3) cycles. seg and an are registered, or derived combinationally from registered state, with no dependence on product settling.

## Test plan
- Load mcand=13 (toggle=0) and mplier=11 (toggle=1), then pulse start. Required: busy for 16 cycles, a single valid pulse at edge k+16, product=0x0000008F.
- Load mcand=0xFFFF and mplier=0xFFFF, then start. Required: product=0xFFFE0001. This exercises carry on every add.
- Load mcand=0x1234 and mplier=0, then start. Required: valid at the accepting edge, product=0, busy never asserted.
- Start 0x00FF×0x0100; push mcand=0x0002 at cycle 5; hold start high throughout. Required: first result 0x0000FF00, then a second run using 0x0002 gives product 0x00000200.
- Start 0xABCD×0x0003 and assert rst_n=0 at cycle 8. Required: all outputs go to reset values immediately, with no valid. After release, start 0xABCD×0x0003 again gives 0x00020367.
- With REFRESH_BITS=4 and product=0x89ABCDEF, step through 8 digit slots. Required: an walks 0xFE→0x7F, and seg shows F,E,D,C,B,A,9,8 in order.
